// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer
//   Adapter between a valid/ready operand stream and an 8-bit shift-add
//   multiplier that takes both operands over one shared data bus.
//   One operand pair is in flight at a time:
//     accept {a,b} -> drive a with a start pulse -> drive b -> wait for done
//     -> offer the registered product downstream.
//   A watchdog aborts the wait if the multiplier never reports done. An
//   aborted result has out_timeout=1 and out_product=0.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     operand pair valid
//   in_ready     sequencer can accept a pair (IDLE only)
//   in_a         multiplicand
//   in_b         multiplier
//   mul_start    one-cycle start pulse to the multiplier
//   mul_data     shared operand bus to the multiplier data input
//   mul_done     multiplier done (level)
//   mul_product  multiplier product
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_product  registered product (0 on timeout)
//   out_timeout  result is a watchdog abort
//   busy         sequencer is not IDLE
module mul_operand_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_data,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 out_timeout,
  output logic                 busy
);

  localparam int WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WIDTH-1:0]    b_hold;
  logic [WDOG_W-1:0]   wdog;
  logic                wdog_last;
  logic                accept;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = in_ready && in_valid;
  assign wdog_last = (wdog == WDOG_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; mul_done only matters in S_WAIT so a done level left
  // over from the previous operation cannot end the wait early.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_SEND_A;
      S_SEND_A: state_next = S_SEND_B;
      S_SEND_B: state_next = S_WAIT;
      S_WAIT:   if (mul_done || wdog_last) state_next = S_RESULT;
      S_RESULT: if (out_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Registered outputs, operand hold and watchdog.
  // mul_start and mul_data are loaded one edge ahead so that they are valid
  // during the cycle the FSM spends in S_SEND_A / S_SEND_B.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_start   <= 1'b0;
      mul_data    <= '0;
      b_hold      <= '0;
      wdog        <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_timeout <= 1'b0;
    end else begin
      mul_start <= accept;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mul_data <= in_a;
            b_hold   <= in_b;
          end
        end
        S_SEND_A: begin
          mul_data <= b_hold;
        end
        S_SEND_B: begin
          wdog <= '0;
        end
        S_WAIT: begin
          // done wins over a simultaneous watchdog expiry; the counter stops
          // at its last value instead of wrapping
          if (mul_done) begin
            out_product <= mul_product;
            out_timeout <= 1'b0;
            out_valid   <= 1'b1;
          end else if (wdog_last) begin
            out_product <= '0;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
module tb_mul_operand_sequencer;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic                mul_start;
  logic [WIDTH-1:0]    mul_data;
  logic                mul_done;
  logic [2*WIDTH-1:0]  mul_product;
  logic                out_valid;
  logic                out_ready;
  logic [2*WIDTH-1:0]  out_product;
  logic                out_timeout;
  logic                busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*WIDTH-1:0] prod_prev = 16'hBEEF;

  mul_operand_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_start   (mul_start),
    .mul_data    (mul_data),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_timeout (out_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Multiplier stand-in for cycle c of an operation (c=0 is the accept cycle).
  // It produces the product of what it saw on the bus, available from cycle 3;
  // before that the previous product is still on its output.
  task automatic drive_model(input int c, input int done_cyc, input bit stale,
                             input logic [WIDTH-1:0] ca, input logic [WIDTH-1:0] cb);
    mul_done    = stale ? 1'b1 : (done_cyc >= 0 && c >= done_cyc);
    mul_product = (c >= 3) ? ca * cb : prod_prev;
  endtask

  // One full transaction. done_cyc: cycle (from accept) at which done rises,
  // -1 for never. bp: cycles of out_ready=0 after out_valid.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int done_cyc, input int bp, input bit stale);
    logic [WIDTH-1:0]   ca;
    logic [WIDTH-1:0]   cb;
    logic [2*WIDTH-1:0] exp_p;
    logic [2*WIDTH-1:0] held_p;
    logic               held_t;
    int  d;
    int  exp_rise;
    bit  exp_to;
    int  c;
    bit  seen;
    ca = '0;
    cb = '0;
    // Done is only honoured from the first WAIT cycle (cycle 3); the last
    // WAIT cycle is TIMEOUT+2, and the result shows one cycle later.
    if (stale) d = 3;
    else if (done_cyc < 0) d = 1 << 30;
    else d = (done_cyc < 3) ? 3 : done_cyc;
    exp_to   = (d > TIMEOUT + 2);
    exp_rise = exp_to ? TIMEOUT + 3 : d + 1;
    exp_p    = exp_to ? '0 : a * b;

    check("idle_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b0;
    drive_model(0, done_cyc, stale, ca, cb);
    tick();
    c    = 1;
    seen = 1'b0;
    while (c <= TIMEOUT + 10 && !seen) begin
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        if (c == 1) begin
          check("start_c1", mul_start, 1);
          check("data_a_c1", mul_data, a);
          check("busy_c1", busy, 1);
          ca = mul_data;
        end
        if (c == 2) begin
          check("start_c2", mul_start, 0);
          check("data_b_c2", mul_data, b);
          cb = mul_data;
        end
        check("in_ready_busy", in_ready, 0);
        in_valid = 1'($urandom_range(0, 1));
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        drive_model(c, done_cyc, stale, ca, cb);
        tick();
        c++;
      end
    end
    check("out_valid_seen", seen, 1);
    if (seen) begin
      check("rise_cycle", c, exp_rise);
      check("product", out_product, exp_p);
      check("timeout_flag", out_timeout, exp_to);
      held_p = out_product;
      held_t = out_timeout;
      for (int i = 0; i < bp; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        tick();
        check("bp_valid", out_valid, 1);
        check("bp_product", out_product, held_p);
        check("bp_timeout", out_timeout, held_t);
        check("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("done_valid_low", out_valid, 0);
      check("done_in_ready", in_ready, 1);
      check("done_busy", busy, 0);
    end
    in_valid  = 1'b0;
    prod_prev = ca * cb;
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    mul_done    = 1'b0;
    mul_product = '0;
    out_ready   = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_start", mul_start, 0);
    check("rst_data", mul_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_product", out_product, 0);
    check("rst_timeout", out_timeout, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    run_op(8'd7,   8'd9,   11, 0, 1'b0);
    run_op(8'd255, 8'd255, 11, 0, 1'b0);
    run_op(8'd0,   8'd200, 5,  0, 1'b0);
    run_op(8'd13,  8'd17,  8,  5, 1'b0);
    run_op(8'd100, 8'd3,   -1, 2, 1'b0);
    run_op(8'd21,  8'd2,   TIMEOUT + 2, 0, 1'b0);
    run_op(8'd22,  8'd2,   TIMEOUT + 3, 0, 1'b0);
    run_op(8'd6,   8'd7,   1,  0, 1'b0);

    mul_done = 1'b1;
    run_op(8'd3, 8'd4, 0, 0, 1'b1);
    run_op(8'd5, 8'd6, 0, 1, 1'b1);
    mul_done = 1'b0;

    // Reset in the middle of WAIT
    in_valid = 1'b1;
    in_a     = 8'd9;
    in_b     = 8'd9;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("busy_before_reset", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_start", mul_start, 0);
    mul_done    = 1'b1;
    mul_product = 16'hABCD;
    repeat (4) begin
      tick();
      check("late_done_ignored", out_valid, 0);
    end
    mul_done = 1'b0;
    run_op(8'd2, 8'd3, 6, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      int dc;
      dc = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 20));
      run_op(WIDTH'($urandom), WIDTH'($urandom), dc, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
